// File: rtl/soc_simple_pll_seq_if.sv
// Interface for the soc_simple PLL reset/lock sequencer.
// The master side is the sequencer and the slave side is the PLL and system environment.
interface soc_simple_pll_seq_if;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [7:0] loss_count;

  modport master (
    input  locked,
    input  relock_req,
    output pll_rst,
    output sys_rst,
    output ready,
    output fail,
    output loss_count
  );

  modport slave (
    output locked,
    output relock_req,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  fail,
    input  loss_count
  );
endinterface

// File: rtl/soc_simple_pll_seq.sv
// PLL reset and lock sequencer. It runs on refclk, qualifies locked and releases sys_rst.
// Optional lock-loss counter: define PLL_SEQ_LOSS_CNT_EN.
module soc_simple_pll_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  soc_simple_pll_seq_if.master   bus
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_nxt;
  logic               locked_m;
  logic               locked_s;
  logic               relock_q;
  logic               timeout;
  logic               pll_rst_r;
  logic               sys_rst_r;
  logic               ready_r;
  logic               fail_r;

  // locked is asynchronous to refclk; locked_s is the only copy the FSM looks at
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= bus.locked;
      locked_s <= locked_m;
    end
  end

  // Requests are only captured where they have an effect, so they act one edge after sampling
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      relock_q <= 1'b0;
    end else begin
      relock_q <= bus.relock_req && ((state == RUN) || (state == FAIL));
    end
  end

  always_comb begin
    state_nxt = state;
    retry_nxt = retry;
    timeout   = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s)               state_nxt = STABLE;
        else if (cnt == LOCK_LAST)  timeout   = 1'b1;
      end
      STABLE: begin
        if (!locked_s) begin
          timeout = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end
      end
      RUN: begin
        if (!locked_s || relock_q) state_nxt = RESET_PLL;
      end
      FAIL: begin
        if (relock_q) begin
          state_nxt = RESET_PLL;
          retry_nxt = '0;
        end
      end
      default: state_nxt = RESET_PLL;
    endcase
    // A lock glitch in STABLE consumes a retry just like a timeout, so the retry loop terminates
    if (timeout) begin
      if (retry == RETRY_LAST) begin
        state_nxt = FAIL;
      end else begin
        state_nxt = RESET_PLL;
        retry_nxt = retry + RETRY_W'(1);
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= RESET_PLL;
      retry <= '0;
    end else begin
      state <= state_nxt;
      retry <= retry_nxt;
    end
  end

  // Shared counter restarts on every state change; exit compares keep it below CNT_MAX
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == RESET_PLL) || (state == WAIT_LOCK) || (state == STABLE)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Outputs are registered from the next-state decode so they switch together with state
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_r <= 1'b1;
      sys_rst_r <= 1'b1;
      ready_r   <= 1'b0;
      fail_r    <= 1'b0;
    end else begin
      pll_rst_r <= (state_nxt == RESET_PLL);
      sys_rst_r <= (state_nxt != RUN);
      ready_r   <= (state_nxt == RUN);
      fail_r    <= (state_nxt == FAIL);
    end
  end

  assign bus.pll_rst = pll_rst_r;
  assign bus.sys_rst = sys_rst_r;
  assign bus.ready   = ready_r;
  assign bus.fail    = fail_r;

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic       lock_loss;
  logic [7:0] loss_cnt;

  assign lock_loss = (state == RUN) && !locked_s;

  // Counts only lock-loss exits from RUN, saturating; cleared only by rst
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if (lock_loss && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign bus.loss_count = loss_cnt;
`else
  assign bus.loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_soc_simple_pll_seq.sv
// Directed bench for soc_simple_pll_seq with small parameters.
// It expects loss_count to be active when PLL_SEQ_LOSS_CNT_EN is defined.
module tb_soc_simple_pll_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int ATTEMPT       = RST_CYCLES + LOCK_TIMEOUT;
  localparam int FAIL_AT       = (MAX_RETRIES + 1) * ATTEMPT;
`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam int LOSS_EN = 1;
`else
  localparam int LOSS_EN = 0;
`endif

  // Output vector order is {pll_rst, sys_rst, ready, fail}
  typedef struct {
    int         edge_no;
    logic       locked;
    logic       relock;
    logic [3:0] exp_out;
    int         exp_loss;
  } vec_t;

  logic refclk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;
  vec_t vecs[$];

  soc_simple_pll_seq_if bus();

  soc_simple_pll_seq #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus.master)
  );

  always #5 refclk = ~refclk;

  function automatic logic [3:0] outs();
    return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail};
  endfunction

  // Expected outputs r edges after entering RESET_PLL with locked held low
  function automatic logic [3:0] nolock_exp(input int r);
    if (r >= FAIL_AT) return 4'b0101;
    return ((r % ATTEMPT) < RST_CYCLES) ? 4'b1100 : 4'b0100;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    edge_no++;
  endtask

  task automatic do_reset(input logic lk);
    rst            = 1'b1;
    bus.locked     = lk;
    bus.relock_req = 1'b0;
    repeat (2) @(posedge refclk);
    @(negedge refclk);
    rst     = 1'b0;
    edge_no = 0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.locked     = v.locked;
    bus.relock_req = v.relock;
    while (edge_no < v.edge_no) begin
      tick();
      bus.relock_req = 1'b0;
    end
  endtask

  task automatic run_glitch(input int n);
    do_reset(1'b1);
    for (int e = 1; e <= 40; e++) begin
      bus.locked = !((e == 9) || (n >= 2 && e == 20) || (n >= 3 && e == 31));
      tick();
      if (e == 10) check_output($sformatf("glitch%0d e10", n), 32'(outs()), 32'(4'b0100));
      if (e == 11) check_output($sformatf("glitch%0d e11", n), 32'(outs()), 32'(4'b1100));
      if (e == 22) begin
        check_output($sformatf("glitch%0d e22", n), 32'(outs()), 32'(4'b1100));
        check_output($sformatf("glitch%0d retry", n), 32'(dut.retry), 32'd2);
      end
      if (n == 2 && e == 34) check_output("glitch2 e34", 32'(outs()), 32'(4'b0100));
      if (n == 2 && e == 35) check_output("glitch2 run", 32'(outs()), 32'(4'b0010));
      if (n == 3 && e == 32) check_output("glitch3 e32", 32'(outs()), 32'(4'b0100));
      if (n == 3 && e == 33) check_output("glitch3 fail", 32'(outs()), 32'(4'b0101));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic prev_pll;
    int   falls;

    // Clean lock at edge 10, lock loss at edge 26, relock request at edge 42
    vecs.push_back('{1,  1'b0, 1'b0, 4'b1100, 0});
    vecs.push_back('{3,  1'b0, 1'b0, 4'b1100, 0});
    vecs.push_back('{4,  1'b0, 1'b0, 4'b0100, 0});
    vecs.push_back('{9,  1'b0, 1'b0, 4'b0100, 0});
    vecs.push_back('{10, 1'b1, 1'b0, 4'b0100, 0});
    vecs.push_back('{12, 1'b1, 1'b0, 4'b0100, 0});
    vecs.push_back('{19, 1'b1, 1'b0, 4'b0100, 0});
    vecs.push_back('{20, 1'b1, 1'b0, 4'b0010, 0});
    vecs.push_back('{25, 1'b1, 1'b0, 4'b0010, 0});
    vecs.push_back('{26, 1'b0, 1'b0, 4'b0010, 0});
    vecs.push_back('{27, 1'b1, 1'b0, 4'b0010, 0});
    vecs.push_back('{28, 1'b1, 1'b0, 4'b1100, 1});
    vecs.push_back('{31, 1'b1, 1'b0, 4'b1100, 1});
    vecs.push_back('{32, 1'b1, 1'b0, 4'b0100, 1});
    vecs.push_back('{33, 1'b1, 1'b0, 4'b0100, 1});
    vecs.push_back('{40, 1'b1, 1'b0, 4'b0100, 1});
    vecs.push_back('{41, 1'b1, 1'b0, 4'b0010, 1});
    vecs.push_back('{42, 1'b1, 1'b1, 4'b0010, 1});
    vecs.push_back('{43, 1'b1, 1'b0, 4'b1100, 1});
    vecs.push_back('{46, 1'b1, 1'b0, 4'b1100, 1});
    vecs.push_back('{47, 1'b1, 1'b0, 4'b0100, 1});
    vecs.push_back('{55, 1'b1, 1'b0, 4'b0100, 1});
    vecs.push_back('{56, 1'b1, 1'b0, 4'b0010, 1});

    rst            = 1'b1;
    bus.locked     = 1'b0;
    bus.relock_req = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    check_output("reset outs", 32'(outs()), 32'(4'b1100));
    check_output("reset loss", 32'(bus.loss_count), 32'd0);
    do_reset(1'b0);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("table e%0d outs", vecs[i].edge_no), 32'(outs()), 32'(vecs[i].exp_out));
      check_output($sformatf("table e%0d loss", vecs[i].edge_no), 32'(bus.loss_count),
                   32'(vecs[i].exp_loss * LOSS_EN));
    end

    // Asynchronous reset in RUN takes effect with no clock edge
    #3;
    rst = 1'b1;
    #1;
    check_output("async rst outs", 32'(outs()), 32'(4'b1100));
    check_output("async rst loss", 32'(bus.loss_count), 32'd0);

    // Never lock: three attempts, then FAIL is held
    do_reset(1'b0);
    prev_pll = 1'b1;
    falls    = 0;
    while (edge_no < 100) begin
      tick();
      if (prev_pll && !bus.pll_rst) falls++;
      prev_pll = bus.pll_rst;
      check_output($sformatf("nolock e%0d", edge_no), 32'(outs()), 32'(nolock_exp(edge_no)));
    end
    check_output("nolock pulses", 32'(falls), 32'd3);

    // Restart from FAIL: sampled at edge 101, acted on at edge 102
    bus.relock_req = 1'b1;
    tick();
    bus.relock_req = 1'b0;
    check_output("restart hold", 32'(outs()), 32'(4'b0101));
    tick();
    check_output("restart outs", 32'(outs()), 32'(4'b1100));
    check_output("restart retry", 32'(dut.retry), 32'd0);
    while (edge_no < 102 + FAIL_AT + 2) begin
      tick();
      check_output($sformatf("restart e%0d", edge_no), 32'(outs()), 32'(nolock_exp(edge_no - 102)));
    end

    run_glitch(2);
    run_glitch(3);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/soc_simple_pll_seq.md
# soc_simple_pll_seq

Reset and lock sequencer for the soc_simple PLL (50 MHz reference in, single output clock). It runs on the PLL reference clock and pulses the PLL reset. It qualifies `locked` through a synchronizer and a stability window, then releases the system reset for the PLL-clocked domain. On lock loss it re-asserts system reset and relocks the PLL. If the PLL does not lock after a bounded number of retries, it stops in a fail state.

## Interface
Parameters:
- `RST_CYCLES`, 16: pll_rst pulse length, refclk cycles (≥1)
- `LOCK_TIMEOUT`, 50000: max cycles waiting for lock per attempt (1 ms at 50 MHz)
- `STABLE_CYCLES`, 1024: cycles `locked` must stay high before release (≥1)
- `MAX_RETRIES`, 3: retries after the first attempt; total attempts = MAX_RETRIES+1

Ports:
- `refclk`  in  1  free-running reference clock; sole clock of the block
- `rst`  in  1  asynchronous, active-high reset
- `locked`  in  1  PLL lock indicator, asynchronous to refclk
- `relock_req`  in  1  single-cycle request: force relock (RUN) or restart (FAIL)
- `pll_rst`  out  1  reset to PLL, active-high
- `sys_rst`  out  1  system reset for downstream logic, active-high
- `ready`  out  1  high only in RUN
- `fail`  out  1  high only in FAIL
- `loss_count`  out  8  lock-loss counter (see Configuration)

## Operation
- `locked` passes through a 2-flop synchronizer; `locked_s` is the second flop. It is cleared by `rst`.
- Counters:
  - `cnt` is a single shared counter, cleared on every state entry and incremented each cycle while in a counting state.
  - The `cnt` width is clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES); it never wraps.
  - `retry` is wide enough to hold MAX_RETRIES.
- States:
  - **RESET_PLL**
    - `pll_rst`=1.
    - When `cnt`==RST_CYCLES-1, go to WAIT_LOCK.
  - **WAIT_LOCK**
    - If `locked_s`, go to STABLE.
    - Else, when `cnt`==LOCK_TIMEOUT-1, take a timeout event.
  - **STABLE**
    - If `!locked_s`, take a timeout event. A glitch counts as a failed attempt, which guarantees termination.
    - Else, when `cnt`==STABLE_CYCLES-1, go to RUN and clear `retry`.
  - **RUN**
    - `sys_rst`=0, `ready`=1.
    - If `!locked_s`, go to RESET_PLL. This does not consume a retry.
    - Else, if `relock_req`, go to RESET_PLL.
  - **FAIL**
    - `fail`=1, `sys_rst`=1, `pll_rst`=0.
    - On `relock_req`, clear `retry` and go to RESET_PLL.
- Timeout event:
  - If `retry`==MAX_RETRIES, go to FAIL.
  - Else, `retry`++ and go to RESET_PLL.
- `relock_req` is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- If lock loss and `relock_req` occur together in RUN, there is a single transition to RESET_PLL.
- All outputs come from dedicated flops, loaded with the next-state decode, so they are glitch-free and change on the same edge as the state.

## Timing
- Reset values:
  - state RESET_PLL, `cnt`=0, `retry`=0
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `loss_count`=0
- Asserting `rst` forces these values immediately (asynchronously), in any state. Deassertion is expected to be synchronized externally to refclk.
- After `rst` falls, `pll_rst` stays high for exactly RST_CYCLES rising edges.
- Let edge k be the first edge sampling `locked`=1:
  - `locked_s`=1 after edge k+1.
  - STABLE is entered at edge k+2.
  - `sys_rst`→0 and `ready`→1 at edge k+2+STABLE_CYCLES.
- Lock loss in RUN:
  - Let edge k be the first edge sampling `locked`=0.
  - `sys_rst`→1, `ready`→0 and `pll_rst`→1 at edge k+2.
  - A single-cycle low pulse on `locked` is sufficient to trigger this.
- `relock_req` sampled at edge k, in RUN or FAIL: outputs change at edge k+1.
- Worst-case time to FAIL with no lock: (MAX_RETRIES+1)·(RST_CYCLES+LOCK_TIMEOUT) cycles.

## Configuration
- Macro `PLL_SEQ_LOSS_CNT_EN`.
- Defined:
  - `loss_count` increments on each RUN→RESET_PLL transition caused by lock loss.
  - Transitions caused by `relock_req` are not counted.
  - Saturates at 255.
  - Cleared only by `rst`.
- Undefined: the counter logic is removed and `loss_count` is tied to 8'd0.

## Test plan
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Clean lock:** release `rst`; raise `locked` so it is first sampled at edge 10 and hold it → `pll_rst` high for edges 1–4, `sys_rst`=0 and `ready`=1 from edge 20.
- **Never lock:** hold `locked`=0 → exactly 3 `pll_rst` pulses of 4 cycles, each followed by 20 cycles low; then `fail`=1, `pll_rst`=0, `sys_rst`=1, held indefinitely.
- **Loss in RUN:** from RUN, pulse `locked` low for 1 cycle at edge k → `sys_rst`=1 and `pll_rst`=1 at edge k+2, relock completes; with the macro defined, `loss_count`=1.
- **Glitch in STABLE:** drop `locked` at STABLE cnt=5, twice in successive attempts, then hold high → `retry` reaches 2 and RUN is still reached. Adding a third failed attempt gives FAIL.
- **Restart from FAIL:** pulse `relock_req` in FAIL → `fail`=0 and `pll_rst`=1 at the next edge; `retry`=0.
- **Reset mid-RUN:** assert `rst` between edges → `sys_rst`=1, `pll_rst`=1, `ready`=0 and `loss_count`=0 without waiting for a clock edge.
